// File: rtl/lvt_controller.sv
// Live-value-table controller for a two-bank, two-read-port register file: it tracks which bank holds each entry.
// Define LVT_BYPASS_EN for write-first selector reads; the default build reads first.
module lvt_controller #(
    parameter int ADDR_WIDTH  = 4,
    parameter int ENTRY_WIDTH = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   we0_i,
    input  logic [ADDR_WIDTH-1:0]  waddr0_i,
    input  logic                   we1_i,
    input  logic [ADDR_WIDTH-1:0]  waddr1_i,
    input  logic [ADDR_WIDTH-1:0]  raddr0_i,
    input  logic [ADDR_WIDTH-1:0]  raddr1_i,
    output logic [ENTRY_WIDTH-1:0] sel0_o,
    output logic [ENTRY_WIDTH-1:0] sel1_o,
    output logic                   init_we_o,
    output logic [ADDR_WIDTH-1:0]  init_addr_o,
    output logic                   ready_o,
    output logic                   collision_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ENTRY_WIDTH-1:0] BANK_0 = '0;
    localparam logic [ENTRY_WIDTH-1:0] BANK_1 = ENTRY_WIDTH'(1);

    typedef enum logic {INIT, RUN} state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  cnt;
    logic [ENTRY_WIDTH-1:0] tbl [DEPTH];
    logic [ENTRY_WIDTH-1:0] rd0;
    logic [ENTRY_WIDTH-1:0] rd1;

    assign init_addr_o = cnt;

`ifdef LVT_BYPASS_EN
    // Forward this cycle's writes to the read ports; port 1 is applied last so it wins.
    always_comb begin
        rd0 = tbl[raddr0_i];
        rd1 = tbl[raddr1_i];
        if (we0_i && (waddr0_i == raddr0_i)) rd0 = BANK_0;
        if (we1_i && (waddr1_i == raddr0_i)) rd0 = BANK_1;
        if (we0_i && (waddr0_i == raddr1_i)) rd1 = BANK_0;
        if (we1_i && (waddr1_i == raddr1_i)) rd1 = BANK_1;
    end
`else
    always_comb begin
        rd0 = tbl[raddr0_i];
        rd1 = tbl[raddr1_i];
    end
`endif

    // The table has no reset; the INIT sweep clears it one entry per cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= INIT;
            cnt         <= '0;
            ready_o     <= 1'b0;
            init_we_o   <= 1'b1;
            sel0_o      <= BANK_0;
            sel1_o      <= BANK_0;
            collision_o <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    tbl[cnt]    <= BANK_0;
                    sel0_o      <= BANK_0;
                    sel1_o      <= BANK_0;
                    collision_o <= 1'b0;
                    if (cnt == '1) begin
                        state     <= RUN;
                        ready_o   <= 1'b1;
                        init_we_o <= 1'b0;
                    end else begin
                        cnt <= cnt + ADDR_WIDTH'(1);
                    end
                end
                RUN: begin
                    // Port 1 write follows port 0 so it wins on an address collision.
                    if (we0_i) tbl[waddr0_i] <= BANK_0;
                    if (we1_i) tbl[waddr1_i] <= BANK_1;
                    sel0_o      <= rd0;
                    sel1_o      <= rd1;
                    collision_o <= we0_i && we1_i && (waddr0_i == waddr1_i);
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_lvt_controller.sv
// Randomised self-checking bench for lvt_controller against a behavioural table model.
// Expectations follow LVT_BYPASS_EN the same way the design does.
module tb_lvt_controller;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst, we0, we1;
    logic [AW-1:0] waddr0, waddr1, raddr0, raddr1;
    logic          sel0, sel1, init_we, ready, collision;
    logic [AW-1:0] init_addr;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int mem [DEPTH];
    bit m_run;
    int m_pos;
    int m_sel0, m_sel1, m_col;
    int col_seen;

    lvt_controller #(.ADDR_WIDTH(AW), .ENTRY_WIDTH(1)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .we0_i       (we0),
        .waddr0_i    (waddr0),
        .we1_i       (we1),
        .waddr1_i    (waddr1),
        .raddr0_i    (raddr0),
        .raddr1_i    (raddr1),
        .sel0_o      (sel0),
        .sel1_o      (sel1),
        .init_we_o   (init_we),
        .init_addr_o (init_addr),
        .ready_o     (ready),
        .collision_o (collision)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0;
        waddr0 = '0; waddr1 = '0; raddr0 = '0; raddr1 = '0;
    endtask

    // Advance the model by one clock, let the DUT take the edge, then compare.
    task automatic cycle();
        int pre [DEPTH];
        int post [DEPTH];
        if (rst) begin
            m_run = 0; m_pos = 0;
            m_sel0 = 0; m_sel1 = 0; m_col = 0;
        end else if (!m_run) begin
            mem[m_pos] = 0;
            if (m_pos == DEPTH - 1) m_run = 1;
            else m_pos++;
            m_sel0 = 0; m_sel1 = 0; m_col = 0;
        end else begin
            pre = mem;
            if (we0) mem[int'(waddr0)] = 0;
            if (we1) mem[int'(waddr1)] = 1;
            post = mem;
`ifdef LVT_BYPASS_EN
            m_sel0 = post[int'(raddr0)];
            m_sel1 = post[int'(raddr1)];
`else
            m_sel0 = pre[int'(raddr0)];
            m_sel1 = pre[int'(raddr1)];
`endif
            m_col = (we0 && we1 && waddr0 == waddr1) ? 1 : 0;
        end
        @(posedge clk);
        #1;
        if (collision) col_seen++;
        check("ready", int'(ready), m_run ? 1 : 0);
        check("init_we", int'(init_we), m_run ? 0 : 1);
        if (!m_run) check("init_addr", int'(init_addr), m_pos);
        check("sel0", int'(sel0), m_sel0);
        check("sel1", int'(sel1), m_sel1);
        check("collision", int'(collision), m_col);
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) mem[i] = 0;
        m_run = 0; m_pos = 0; col_seen = 0;
        rst = 1'b1;
        idle();
        @(negedge clk);
        cycle();
        check("rst_init_addr", int'(init_addr), 0);
        check("rst_ready", int'(ready), 0);
        rst = 1'b0;

        // Idle INIT sweep: init_addr steps 0..15, then ready.
        for (int i = 0; i < DEPTH; i++) begin
            check("sweep_addr", int'(init_addr), i);
            cycle();
        end
        check("sweep_ready", int'(ready), 1);

        // Reset mid-INIT when init_addr reaches 7.
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int i = 0; i < 7; i++) cycle();
        check("pre_rst_addr", int'(init_addr), 7);
        rst = 1'b1; cycle(); rst = 1'b0;
        check("midrst_addr", int'(init_addr), 0);
        check("midrst_ready", int'(ready), 0);
        n = 0;
        while (!ready && n < 40) begin
            cycle();
            n++;
        end
        check("init_len", n, 16);

        // Writes during INIT must be ignored.
        rst = 1'b1; cycle(); rst = 1'b0;
        col_seen = 0;
        for (int i = 0; i < DEPTH; i++) begin
            we0 = 1'b1; we1 = 1'b1;
            waddr0 = AW'($urandom_range(0, DEPTH - 1));
            waddr1 = (i % 2 == 0) ? waddr0 : AW'($urandom_range(0, DEPTH - 1));
            cycle();
        end
        idle();
        check("init_done", int'(ready), 1);
        for (int i = 0; i < DEPTH; i++) begin
            raddr0 = AW'(i); raddr1 = AW'(DEPTH - 1 - i);
            cycle();
            check("clear_rd0", int'(sel0), 0);
            check("clear_rd1", int'(sel1), 0);
        end
        check("init_no_col", col_seen, 0);
        idle();

        // Port-1 write to 5, read back on port 0.
        we1 = 1'b1; waddr1 = AW'(5); cycle();
        idle(); raddr0 = AW'(5); cycle();
        check("wr1_rd5", int'(sel0), 1);

        // Collision at 9: port 1 wins, one-cycle pulse.
        idle(); we0 = 1'b1; we1 = 1'b1; waddr0 = AW'(9); waddr1 = AW'(9); cycle();
        check("col_pulse", int'(collision), 1);
        idle(); raddr0 = AW'(9); cycle();
        check("col_clear", int'(collision), 0);
        check("col_rd9", int'(sel0), 1);
        idle(); we0 = 1'b1; waddr0 = AW'(9); cycle();
        idle(); raddr0 = AW'(9); cycle();
        check("wr0_rd9", int'(sel0), 0);

        // Same-cycle write/read of entry 3.
        idle(); we1 = 1'b1; waddr1 = AW'(3); raddr1 = AW'(3); cycle();
`ifdef LVT_BYPASS_EN
        check("same_cycle_rd3", int'(sel1), 1);
`else
        check("same_cycle_rd3", int'(sel1), 0);
`endif
        idle(); raddr1 = AW'(3); cycle();
        check("later_rd3", int'(sel1), 1);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                waddr0 = AW'($urandom_range(0, 3));
                waddr1 = AW'($urandom_range(0, 3));
                raddr0 = AW'($urandom_range(0, 3));
                raddr1 = AW'($urandom_range(0, 3));
            end else begin
                waddr0 = AW'($urandom_range(0, DEPTH - 1));
                waddr1 = AW'($urandom_range(0, DEPTH - 1));
                raddr0 = AW'($urandom_range(0, DEPTH - 1));
                raddr1 = AW'($urandom_range(0, DEPTH - 1));
            end
            cycle();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
